// File: rtl/loa_pkg.sv
// Shared constants and types for the lower-part-OR approximate adder.
package loa_pkg;
  localparam int DATA_W            = 32;
  localparam int RES_W             = 33;
  localparam int CLA_GROUP_W       = 4;
  localparam int LOA_LOWER_W_DFLT  = 8;

  typedef logic [RES_W-1:0] res_t;
endpackage

// File: rtl/lower_part_or_carry_lookahead_adder32_cla4_group.sv
// 4-bit carry-lookahead slice: local sum plus group propagate/generate for the next level.
module cla4_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       P,
  output logic       G
);
  logic [3:0] w_p, w_g;
  logic [3:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Bit carries expanded as flat sum-of-products, no ripple inside the slice
  assign w_c[0] = c_in;
  assign w_c[1] = w_g[0] | (w_p[0] & c_in);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & c_in);

  assign s = w_p ^ w_c;
  assign P = &w_p;
  assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

// File: rtl/lower_part_or_carry_lookahead_adder32.sv
// Registered approximate adder: OR on the low LOWER_WIDTH bits, two-level CLA above.
// Optional macro LOA_CARRY_PREDICT_EN feeds the upper adder a carry predicted from the top low bit.
module lower_part_or_carry_lookahead_adder32
  import loa_pkg::*;
#(
  parameter int LOWER_WIDTH = LOA_LOWER_W_DFLT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] add1_i,
  input  logic [DATA_W-1:0] add2_i,
  output res_t              result_o
);
  localparam int U  = DATA_W - LOWER_WIDTH;
  localparam int NG = U / CLA_GROUP_W;

  generate
    if (LOWER_WIDTH < 0 || LOWER_WIDTH > 28 || (LOWER_WIDTH % CLA_GROUP_W) != 0) begin : g_bad_lw
      $error("LOWER_WIDTH must be 0..28 in steps of 4");
    end
  endgenerate

  logic          w_cin;
  logic [U-1:0]  w_hi;
  logic [NG-1:0] w_p, w_g;
  logic [NG:0]   w_c;
  res_t          w_sum;

  generate
    if (LOWER_WIDTH > 0) begin : g_lo
      logic [LOWER_WIDTH-1:0] w_lo;
      assign w_lo = add1_i[LOWER_WIDTH-1:0] | add2_i[LOWER_WIDTH-1:0];
`ifdef LOA_CARRY_PREDICT_EN
      assign w_cin = add1_i[LOWER_WIDTH-1] & add2_i[LOWER_WIDTH-1];
`else
      assign w_cin = 1'b0;
`endif
      assign w_sum = {w_c[NG], w_hi, w_lo};
    end else begin : g_nolo
      assign w_cin = 1'b0;
      assign w_sum = {w_c[NG], w_hi};
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      cla4_group u_grp (
        .a    (add1_i[LOWER_WIDTH + CLA_GROUP_W*gi +: CLA_GROUP_W]),
        .b    (add2_i[LOWER_WIDTH + CLA_GROUP_W*gi +: CLA_GROUP_W]),
        .c_in (w_c[gi]),
        .s    (w_hi[CLA_GROUP_W*gi +: CLA_GROUP_W]),
        .P    (w_p[gi]),
        .G    (w_g[gi])
      );
    end
  endgenerate

  // Every group carry is an independent OR of product terms over cin and lower P/G
  always_comb begin
    logic t_term;
    t_term = 1'b0;
    w_c    = '0;
    for (int k = 0; k <= NG; k++) begin
      t_term = w_cin;
      for (int m = 0; m < k; m++) t_term = t_term & w_p[m];
      w_c[k] = t_term;
      for (int j = 0; j < k; j++) begin
        t_term = w_g[j];
        for (int m = j + 1; m < k; m++) t_term = t_term & w_p[m];
        w_c[k] = w_c[k] | t_term;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) result_o <= '0;
    else       result_o <= w_sum;
  end
endmodule

// File: tb/tb_lower_part_or_carry_lookahead_adder32.sv
// Directed plus random checks of the approximate adder against an arithmetic reference.
module tb_lower_part_or_carry_lookahead_adder32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [32:0] res8, res0;
  int          n_pass = 0, n_tot = 0;

`ifdef LOA_CARRY_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  always #5 clk = ~clk;

  lower_part_or_carry_lookahead_adder32 #(.LOWER_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .add1_i(a), .add2_i(b), .result_o(res8));

  lower_part_or_carry_lookahead_adder32 #(.LOWER_WIDTH(0)) dut_exact (
    .clk_i(clk), .rst_i(rst), .add1_i(a), .add2_i(b), .result_o(res0));

  function automatic logic [32:0] ref_sum(logic [31:0] x, logic [31:0] y, int l, bit pred);
    logic [32:0] lo, hi, mask;
    logic        cin;
    mask = (l == 0) ? 33'd0 : ((33'd1 << l) - 33'd1);
    lo   = {1'b0, x | y} & mask;
    cin  = (pred && l > 0) ? (x[l-1] & y[l-1]) : 1'b0;
    hi   = ({1'b0, x} >> l) + ({1'b0, y} >> l) + {32'd0, cin};
    return (hi << l) | lo;
  endfunction

  task automatic chk(string tag, logic [32:0] obs, logic [32:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive at negedge, sample 1 time unit after the capturing posedge
  task automatic step(string tag, logic [31:0] x, logic [31:0] y, logic [32:0] exp8);
    @(negedge clk);
    a = x; b = y;
    @(posedge clk); #1;
    chk(tag, res8, exp8);
    chk({tag, "_exact"}, res0, {1'b0, x} + {1'b0, y});
  endtask

  initial begin
    #1;
    chk("reset_init", res8, 33'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", res8, 33'h0);
    @(negedge clk);
    rst = 1'b0;

    step("exact_match", 32'h5555_5555, 32'hAAAA_AAAA, 33'h0_FFFF_FFFF);
    step("approx_1",    32'h29AF_2430, 32'h7A1B_9ABC, 33'h0_A3CA_BEBC);
    step("approx_2",    32'h2020_2012, 32'hDEAD_BEEF, 33'h0_FECD_DEFF);
    step("carry_out",   32'h8051_9860, 32'h8086_BA3E, 33'h1_00D8_527E);
    step("pred_80",     32'h0000_0080, 32'h0000_0080, PRED ? 33'h0_0000_0180 : 33'h0_0000_0080);
    step("pred_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, PRED ? 33'h1_FFFF_FFFF : 33'h1_FFFF_FEFF);

    // Operands changing between edges must not disturb the register
    #2; a = 32'h1234_5678; b = 32'h0F0F_0F0F;
    #1; chk("hold_between_edges", res8, PRED ? 33'h1_FFFF_FFFF : 33'h1_FFFF_FEFF);

    // Asynchronous reset with no clock edge, then held across two edges
    @(negedge clk); #2;
    rst = 1'b1;
    #1; chk("reset_async", res8, 33'h0);
    chk("reset_async_exact", res0, 33'h0);
    repeat (2) @(posedge clk);
    #1; chk("reset_held", res8, 33'h0);
    @(negedge clk);
    rst = 1'b0;
    a = 32'h0000_0100; b = 32'h0000_0001;
    @(posedge clk); #1;
    chk("first_after_reset", res8, 33'h0_0000_0101);

    // Back-to-back random operands, one result per edge
    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = $urandom;
      if (i % 4 == 0) begin x[7] = 1'b1; y[7] = 1'b1; end
      step($sformatf("rand_%0d", i), x, y, ref_sum(x, y, 8, PRED));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/lower_part_or_carry_lookahead_adder32.md
# lower_part_or_carry_lookahead_adder32

Registered 32-bit approximate adder for error-tolerant datapaths. The low-order bits are "added" with a bitwise OR, and the high-order bits with an exact two-level carry-lookahead adder. It trades accuracy in the low bits for a short carry chain. It sits between operand sources and downstream accumulators as a drop-in, one-cycle-latency adder returning a 33-bit result.

## Interface
- LOWER_WIDTH, default 8: number of low bits computed by OR. Legal values are 0..28 in multiples of 4; an illegal value is an elaboration error.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- add1_i  input  32  operand A, unsigned.
- add2_i  input  32  operand B, unsigned.
- result_o  output  33  registered approximate sum; bit 32 is the carry-out.

## Operation
- Let L = LOWER_WIDTH and U = 32 − L.
- Lower part: sum[L-1:0] = add1_i[L-1:0] | add2_i[L-1:0].
- Carry prediction (see Configuration): cin = add1_i[L-1] & add2_i[L-1]. cin is 0 when L = 0.
- Upper part: sum[32:L] = add1_i[31:L] + add2_i[31:L] + cin, computed exactly as a U-bit sum with its (U+1)th bit as carry-out.
- Upper adder structure:
  - 4-bit CLA groups, each producing group propagate P and group generate G.
  - A second-level lookahead unit computes every group carry-in directly from cin and the lower groups' P/G.
  - No ripple between groups.
- L = 0 with the macro on or off gives an exact 32-bit adder.
- Operands are unsigned. There is no overflow flag; bit 32 carries the full-width carry.

## Timing
- Combinational sum is captured into the result_o register on each rising clk_i edge. Latency is 1 cycle, throughput is 1 result per cycle.
- There is no handshake; inputs are sampled every cycle.
- rst_i asserted clears result_o to 33'h0 immediately, regardless of the clock.
- While rst_i is held, result_o stays 0.
- On the first rising edge after rst_i deasserts, result_o takes the sum of the operands present at that edge.
- Reset asserted mid-stream discards the in-flight result. There is no recovery or replay.
- Operands changing between edges do not affect result_o until the next edge.

## Configuration
- LOA_CARRY_PREDICT_EN defined (production default): cin = add1_i[L-1] & add2_i[L-1], as in Operation.
- LOA_CARRY_PREDICT_EN undefined: cin is tied to 0, and the upper part is add1_i[31:L] + add2_i[31:L].
- The macro has no effect on the lower part, on latency or on reset behaviour.

## Structure
- Package loa_pkg holds:
  - DATA_W = 32.
  - RES_W = 33.
  - CLA_GROUP_W = 4.
  - The default LOWER_WIDTH constant.
  - A typedef for the 33-bit result word.
- Sub-module cla4_group: a 4-bit CLA slice with inputs a[3:0], b[3:0] and c_in, and outputs s[3:0], P and G. It is instantiated U/4 times by generate.
- The group-level lookahead logic, the OR lower part and the output register stay in the top module.

## Test plan
All cases use L = 8 and the macro defined unless noted.
- Reset: assert rst_i asynchronously between edges -> result_o = 0x0_0000_0000 with no clock edge. Hold reset for 2 edges -> result_o stays 0.
- Exact-matching case: 0x5555_5555 + 0xAAAA_AAAA -> result_o = 0x0_FFFF_FFFF one cycle later.
- Approximation error, no predicted carry: 0x29AF_2430 + 0x7A1B_9ABC -> 0x0_A3CA_BEBC (exact sum 0xA3CA_BEEC). 0x2020_2012 + 0xDEAD_BEEF -> 0x0_FECD_DEFF.
- Carry-out: 0x8051_9860 + 0x8086_BA3E -> 0x1_00D8_527E.
- Carry prediction:
  - 0x0000_0080 + 0x0000_0080 -> 0x0_0000_0180.
  - Same operands with the macro undefined -> 0x0_0000_0080.
  - 0xFFFF_FFFF + 0xFFFF_FFFF -> 0x1_FFFF_FFFF.
- Back-to-back: apply a new operand pair every cycle -> each result appears exactly one edge after its operands, with no bubbles. With LOWER_WIDTH = 0, random operands -> result_o equals the exact sum.
